// File: rtl/sc_frog_game_fsm.sv
// Frogger game sequencer: start/load/play/check/hit/level-up/end control with lives, level and traffic-shift divider.
// Registered Moore outputs change one clock after the causing input; no backpressure, inputs are pulses sampled every clock.
module sc_frog_game_fsm #(
  parameter int LIVES_INIT = 3,
  parameter int LEVELS     = 4
) (
  input  logic       sc_frog_game_fsm_CLOCK_50,
  input  logic       sc_frog_game_fsm_RESET_InLow,
  input  logic       sc_frog_game_fsm_start_InLow,
  input  logic       sc_frog_game_fsm_tick_In,
  input  logic       sc_frog_game_fsm_move_In,
  input  logic [1:0] sc_frog_game_fsm_winCode_InBUS,
  output logic       sc_frog_game_fsm_load_Out,
  output logic       sc_frog_game_fsm_shift_Out,
  output logic [1:0] sc_frog_game_fsm_lives_OutBUS,
  output logic [1:0] sc_frog_game_fsm_level_OutBUS,
  output logic [2:0] sc_frog_game_fsm_state_OutBUS,
  output logic       sc_frog_game_fsm_gameOver_Out,
  output logic       sc_frog_game_fsm_gameWin_Out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    PLAY     = 3'd2,
    CHECK    = 3'd3,
    HIT      = 3'd4,
    LEVELUP  = 3'd5,
    GAMEOVER = 3'd6,
    WIN      = 3'd7
  } state_t;

  localparam logic [1:0] LivesInit = 2'(LIVES_INIT);
  localparam logic [1:0] LastLevel = 2'(LEVELS - 1);

  state_t     state, stateNext;
  logic [1:0] lives, livesNext;
  logic [1:0] level, levelNext;
  logic [1:0] divCount, divNext;
  logic       shiftPulse, shiftNext;
  logic       startReq;
  logic [1:0] divLimit;

  assign startReq = ~sc_frog_game_fsm_start_InLow;
  // Higher levels need fewer ticks per shift; the last level shifts on every tick.
  assign divLimit = LastLevel - level;

  always_ff @(posedge sc_frog_game_fsm_CLOCK_50) begin
    if (!sc_frog_game_fsm_RESET_InLow) begin
      state      <= IDLE;
      lives      <= LivesInit;
      level      <= 2'd0;
      divCount   <= 2'd0;
      shiftPulse <= 1'b0;
    end else begin
      state      <= stateNext;
      lives      <= livesNext;
      level      <= levelNext;
      divCount   <= divNext;
      shiftPulse <= shiftNext;
    end
  end

  always_comb begin
    stateNext = state;
    livesNext = lives;
    levelNext = level;
    divNext   = divCount;
    shiftNext = 1'b0;
    case (state)
      IDLE, GAMEOVER, WIN: begin
        if (startReq) begin
          livesNext = LivesInit;
          levelNext = 2'd0;
          stateNext = INIT;
        end
      end
      INIT: begin
        divNext   = 2'd0;
        stateNext = PLAY;
      end
      PLAY: begin
        if (sc_frog_game_fsm_tick_In) begin
          if (divCount == divLimit) begin
            divNext   = 2'd0;
            shiftNext = 1'b1;
          end else begin
            divNext = divCount + 2'd1;
          end
        end
        // A move landing on the shift pulse still yields a single check.
        if (shiftPulse || sc_frog_game_fsm_move_In) begin
          stateNext = CHECK;
        end
      end
      CHECK: begin
        case (sc_frog_game_fsm_winCode_InBUS)
          2'b00:   stateNext = HIT;
          2'b11:   stateNext = LEVELUP;
          default: stateNext = PLAY;
        endcase
      end
      HIT: begin
        if (lives > 2'd1) begin
          livesNext = lives - 2'd1;
          stateNext = INIT;
        end else begin
          livesNext = 2'd0;
          stateNext = GAMEOVER;
        end
      end
      LEVELUP: begin
        if (level == LastLevel) begin
          stateNext = WIN;
        end else begin
          levelNext = level + 2'd1;
          stateNext = INIT;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign sc_frog_game_fsm_load_Out     = (state == INIT);
  assign sc_frog_game_fsm_shift_Out    = shiftPulse;
  assign sc_frog_game_fsm_lives_OutBUS = lives;
  assign sc_frog_game_fsm_level_OutBUS = level;
  assign sc_frog_game_fsm_state_OutBUS = state;
  assign sc_frog_game_fsm_gameOver_Out = (state == GAMEOVER);
  assign sc_frog_game_fsm_gameWin_Out  = (state == WIN);

endmodule

// File: tb/tb_sc_frog_game_fsm.sv
// Directed scenarios plus a randomized run against a rule-level game model.
module tb_sc_frog_game_fsm;
  localparam int LI = 3;
  localparam int LV = 4;

  logic clk = 1'b0;
  logic rstN, startN, tick, move;
  logic [1:0] code;
  logic load, shift, gameOver, gameWin;
  logic [1:0] lives, level;
  logic [2:0] st;
  logic [10:0] obs;
  logic [10:0] e;
  int checks = 0;
  int failures = 0;

  // Rule-level model: counts ticks since last shift (1-based) against ticks-per-shift.
  int mMode, mLives, mLevel, mTicks;
  bit mShift;

  sc_frog_game_fsm #(.LIVES_INIT(LI), .LEVELS(LV)) dut (
    .sc_frog_game_fsm_CLOCK_50(clk),
    .sc_frog_game_fsm_RESET_InLow(rstN),
    .sc_frog_game_fsm_start_InLow(startN),
    .sc_frog_game_fsm_tick_In(tick),
    .sc_frog_game_fsm_move_In(move),
    .sc_frog_game_fsm_winCode_InBUS(code),
    .sc_frog_game_fsm_load_Out(load),
    .sc_frog_game_fsm_shift_Out(shift),
    .sc_frog_game_fsm_lives_OutBUS(lives),
    .sc_frog_game_fsm_level_OutBUS(level),
    .sc_frog_game_fsm_state_OutBUS(st),
    .sc_frog_game_fsm_gameOver_Out(gameOver),
    .sc_frog_game_fsm_gameWin_Out(gameWin)
  );

  always #5 clk = ~clk;

  assign obs = {st, load, shift, lives, level, gameOver, gameWin};

  function automatic logic [10:0] ev(input int s, input bit ld, input bit sh, input int lv, input int lvl);
    return {3'(s), ld, sh, 2'(lv), 2'(lvl), (s == 6), (s == 7)};
  endfunction

  task automatic drive(input bit r, input bit s, input bit t, input bit m, input logic [1:0] c);
    rstN = r; startN = s; tick = t; move = m; code = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1, 1, 0, 0, 2'b10);
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 1, 2'b00);
    e = ev(0, 0, 0, LI, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e); end
  endtask

  task automatic test_start();
    idle();
    e = ev(0, 0, 0, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL idle_hold got=%h exp=%h", obs, e); end
    drive(1, 0, 0, 0, 2'b10);
    e = ev(1, 1, 0, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL start_init got=%h exp=%h", obs, e); end
    idle();
    e = ev(2, 0, 0, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL start_play got=%h exp=%h", obs, e); end
  endtask

  task automatic test_shift();
    int shifts = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 2'b10);
      shifts += int'(shift);
      e = ev(2, 0, 0, 3, 0);
      checks++; if (obs !== e) begin failures++; $display("FAIL shift_early%0d got=%h exp=%h", i, obs, e); end
      idle();
      shifts += int'(shift);
    end
    drive(1, 1, 1, 0, 2'b10);
    shifts += int'(shift);
    e = ev(2, 0, 1, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL shift_pulse got=%h exp=%h", obs, e); end
    drive(1, 1, 1, 0, 2'b10);
    shifts += int'(shift);
    e = ev(3, 0, 0, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL shift_check got=%h exp=%h", obs, e); end
    drive(1, 1, 1, 1, 2'b10);
    shifts += int'(shift);
    e = ev(2, 0, 0, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL check_return got=%h exp=%h", obs, e); end
    checks++; if (shifts != 1) begin failures++; $display("FAIL shift_count got=%0d exp=1", shifts); end
    // One tick arrived in PLAY→CHECK cycle; divider now 1. Three more ticks give the next shift.
    for (int i = 0; i < 2; i++) drive(1, 1, 1, 0, 2'b10);
    drive(1, 1, 1, 0, 2'b10);
    e = ev(2, 0, 1, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL shift_resume got=%h exp=%h", obs, e); end
    drive(1, 1, 0, 0, 2'b10);
    drive(1, 1, 0, 0, 2'b10);
  endtask

  task automatic test_collision();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 1, 2'b10);
      e = ev(3, 0, 0, 3 - k, 0);
      checks++; if (obs !== e) begin failures++; $display("FAIL col_check%0d got=%h exp=%h", k, obs, e); end
      drive(1, 1, 0, 0, 2'b00);
      e = ev(4, 0, 0, 3 - k, 0);
      checks++; if (obs !== e) begin failures++; $display("FAIL col_hit%0d got=%h exp=%h", k, obs, e); end
      idle();
      if (k < 2) begin
        e = ev(1, 1, 0, 2 - k, 0);
        checks++; if (obs !== e) begin failures++; $display("FAIL col_init%0d got=%h exp=%h", k, obs, e); end
        idle();
      end else begin
        e = ev(6, 0, 0, 0, 0);
        checks++; if (obs !== e) begin failures++; $display("FAIL col_gameover got=%h exp=%h", obs, e); end
      end
    end
    drive(1, 1, 1, 1, 2'b00);
    e = ev(6, 0, 0, 0, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL gameover_hold got=%h exp=%h", obs, e); end
    drive(1, 0, 0, 0, 2'b10);
    e = ev(1, 1, 0, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL gameover_restart got=%h exp=%h", obs, e); end
    idle();
  endtask

  task automatic test_levelup();
    for (int lv = 0; lv < 3; lv++) begin
      drive(1, 1, 0, 1, 2'b10);
      drive(1, 1, 0, 0, 2'b11);
      e = ev(5, 0, 0, 3, lv);
      checks++; if (obs !== e) begin failures++; $display("FAIL lvl_up%0d got=%h exp=%h", lv, obs, e); end
      idle();
      e = ev(1, 1, 0, 3, lv + 1);
      checks++; if (obs !== e) begin failures++; $display("FAIL lvl_init%0d got=%h exp=%h", lv, obs, e); end
      idle();
    end
    drive(1, 1, 1, 0, 2'b10);
    e = ev(2, 0, 1, 3, 3);
    checks++; if (obs !== e) begin failures++; $display("FAIL lvl3_shift got=%h exp=%h", obs, e); end
    drive(1, 1, 0, 0, 2'b11);
    drive(1, 1, 0, 0, 2'b11);
    e = ev(5, 0, 0, 3, 3);
    checks++; if (obs !== e) begin failures++; $display("FAIL lvl3_up got=%h exp=%h", obs, e); end
    idle();
    e = ev(7, 0, 0, 3, 3);
    checks++; if (obs !== e) begin failures++; $display("FAIL win got=%h exp=%h", obs, e); end
    drive(1, 1, 1, 1, 2'b00);
    e = ev(7, 0, 0, 3, 3);
    checks++; if (obs !== e) begin failures++; $display("FAIL win_hold got=%h exp=%h", obs, e); end
    drive(1, 0, 0, 0, 2'b10);
    e = ev(1, 1, 0, 3, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL win_restart got=%h exp=%h", obs, e); end
    idle();
  endtask

  task automatic test_simultaneous();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 2'b10);
      drive(1, 1, 1, 0, 2'b10);
      e = ev(2, 0, 1, 3, 0);
      checks++; if (obs !== e) begin failures++; $display("FAIL sim_shift%0d got=%h exp=%h", pass, obs, e); end
      drive(1, 1, 0, 1, 2'b10);
      e = ev(3, 0, 0, 3, 0);
      checks++; if (obs !== e) begin failures++; $display("FAIL sim_check%0d got=%h exp=%h", pass, obs, e); end
      if (pass == 0) begin
        drive(1, 1, 0, 0, 2'b01);
        idle();
        e = ev(2, 0, 0, 3, 0);
        checks++; if (obs !== e) begin failures++; $display("FAIL sim_single got=%h exp=%h", obs, e); end
      end else begin
        drive(1, 0, 0, 0, 2'b00);
        e = ev(4, 0, 0, 3, 0);
        checks++; if (obs !== e) begin failures++; $display("FAIL sim_hit got=%h exp=%h", obs, e); end
        idle();
        e = ev(1, 1, 0, 2, 0);
        checks++; if (obs !== e) begin failures++; $display("FAIL sim_hit_init got=%h exp=%h", obs, e); end
        idle();
      end
    end
  endtask

  task automatic test_reset_in_check();
    drive(1, 1, 0, 1, 2'b10);
    drive(0, 0, 1, 1, 2'b00);
    e = ev(0, 0, 0, LI, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL rst_check got=%h exp=%h", obs, e); end
    idle();
    e = ev(0, 0, 0, LI, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL rst_no_hit got=%h exp=%h", obs, e); end
  endtask

  task automatic model_step(input bit r, input bit s, input bit t, input bit m, input logic [1:0] c);
    bit nextShift = 0;
    bit goCheck;
    if (!r) begin
      mMode = 0; mLives = LI; mLevel = 0; mTicks = 0; mShift = 0;
      return;
    end
    case (mMode)
      0, 6, 7: if (!s) begin mLives = LI; mLevel = 0; mMode = 1; end
      1: begin mTicks = 0; mMode = 2; end
      2: begin
        goCheck = mShift || m;
        if (t) begin
          mTicks++;
          if (mTicks == LV - mLevel) begin mTicks = 0; nextShift = 1; end
        end
        if (goCheck) mMode = 3;
      end
      3: mMode = (c == 2'b00) ? 4 : (c == 2'b11) ? 5 : 2;
      4: begin
        mLives = (mLives > 0) ? mLives - 1 : 0;
        mMode = (mLives == 0) ? 6 : 1;
      end
      5: if (mLevel == LV - 1) mMode = 7; else begin mLevel++; mMode = 1; end
      default: mMode = 0;
    endcase
    mShift = nextShift;
  endtask

  task automatic test_random();
    bit r, s, t, m;
    logic [1:0] c;
    int x;
    model_step(0, 1, 0, 0, 2'b10);
    drive(0, 1, 0, 0, 2'b10);
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 149) != 0);
      s = ($urandom_range(0, 9) != 0);
      t = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 7) == 0);
      x = $urandom_range(0, 5);
      c = (x == 0) ? 2'b00 : (x == 1) ? 2'b11 : (x == 2) ? 2'b01 : 2'b10;
      model_step(r, s, t, m, c);
      drive(r, s, t, m, c);
      e = ev(mMode, (mMode == 1), mShift, mLives, mLevel);
      checks++; if (obs !== e) begin failures++; $display("FAIL rand_cycle%0d got=%h exp=%h", n, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_shift();
    test_collision();
    test_levelup();
    test_simultaneous();
    test_reset_in_check();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
